// File: rtl/cra_dispatch.sv
// cra_dispatch: microsequencer next-address dispatch with DRAM field latch,
// parity check and a 4-entry return stack.
module cra_dispatch (
  input  logic        clk_cra_h,
  input  logic        reset_h,
  input  logic        cra_adv_h,
  input  logic        con_load_dram_l,
  input  logic [7:0]  dram_j_h,
  input  logic [2:0]  dram_a_h,
  input  logic [2:0]  dram_b_h,
  input  logic        dram_odd_parity_h,
  input  logic [2:0]  ir_norm_h,
  input  logic        ir_test_satisfied_h,
  input  logic [10:0] cram_j_h,
  input  logic [2:0]  cram_disp_h,
  input  logic        diag_clr_err_h,
  output logic [10:0] cra_addr_h,
  output logic        dram_par_err_h,
  output logic        stk_ovf_h,
  output logic        stk_unf_h,
  output logic [2:0]  stk_depth_h
);
  typedef enum logic [2:0] {
    D_JUMP, D_DRAM_J, D_DRAM_A, D_DRAM_B, D_NORM, D_TEST, D_CALL, D_RET
  } disp_e;
  disp_e             disp;
  logic [10:0]       addr_q, addr_d, inc;
  logic [3:0][10:0]  stk_q, stk_d;
  logic [2:0]        depth_q, depth_d;
  logic [7:0]        j_q, j_d;
  logic [2:0]        a_q, a_d, b_q, b_d;
  logic              par_q, par_d, chk_q, chk_d;
  logic              err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;
  logic              load, push, pop, par_bad;
  assign disp = disp_e'(cram_disp_h);
  always_comb begin
    addr_d  = addr_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    par_d   = par_q;
    chk_d   = chk_q;
    inc     = addr_q + 11'd1;
    load    = cra_adv_h & ~con_load_dram_l;
    push    = cra_adv_h & (disp == D_CALL);
    pop     = cra_adv_h & (disp == D_RET);
    par_bad = cra_adv_h & chk_q & ~^{j_q, a_q, b_q, par_q};
    if (cra_adv_h) begin
      case (disp)
        D_JUMP:   addr_d = cram_j_h;
        D_DRAM_J: addr_d = {cram_j_h[10:8], j_q};
        D_DRAM_A: addr_d = {cram_j_h[10:3], a_q};
        D_DRAM_B: addr_d = {cram_j_h[10:3], b_q};
        D_NORM:   addr_d = {cram_j_h[10:3], ir_norm_h};
        D_TEST:   addr_d = {cram_j_h[10:1], cram_j_h[0] | ir_test_satisfied_h};
        D_CALL:   addr_d = cram_j_h;
        default:  addr_d = (depth_q == 3'd0) ? 11'd0 : stk_q[0];
      endcase
      chk_d = load;
    end
    // Entry 0 is the top; a push at full depth shifts the oldest out of entry 3.
    if (push) begin
      stk_d   = {stk_q[2:0], inc};
      depth_d = (depth_q == 3'd4) ? 3'd4 : depth_q + 3'd1;
    end
    if (pop) begin
      stk_d   = {11'd0, stk_q[3:1]};
      depth_d = (depth_q == 3'd0) ? 3'd0 : depth_q - 3'd1;
    end
    if (load) begin
      j_d   = dram_j_h;
      a_d   = dram_a_h;
      b_d   = dram_b_h;
      par_d = dram_odd_parity_h;
    end
    err_d = (diag_clr_err_h ? 1'b0 : err_q) | par_bad;
    ovf_d = (diag_clr_err_h ? 1'b0 : ovf_q) | (push & (depth_q == 3'd4));
    unf_d = (diag_clr_err_h ? 1'b0 : unf_q) | (pop & (depth_q == 3'd0));
  end
  always_ff @(posedge clk_cra_h or posedge reset_h) begin
    if (reset_h) begin
      addr_q  <= '0;
      stk_q   <= '0;
      depth_q <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b1;
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      stk_q   <= stk_d;
      depth_q <= depth_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      par_q   <= par_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign cra_addr_h     = addr_q;
  assign dram_par_err_h = err_q;
  assign stk_ovf_h      = ovf_q;
  assign stk_unf_h      = unf_q;
  assign stk_depth_h    = depth_q;
endmodule
